// File: rtl/axi_master_bridge.sv
// Purpose: turns single-word core load/store requests into single-beat AXI4 read/write transactions.
// Latency: 3 cycles from request accept to resp_valid with zero-wait slave; one transaction outstanding.
// Backpressure: req_ready is high only in IDLE; every AXI valid is held until its ready is seen.
module axi_master_bridge #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int LEN_WIDTH  = 4,
    parameter logic [ID_WIDTH-1:0] MASTER_ID = '0
) (
    input  logic                    ACLK,
    input  logic                    ARESETn,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_wstrb,
    output logic                    resp_valid,
    output logic [DATA_WIDTH-1:0]   resp_rdata,
    output logic                    resp_err,
    output logic [ID_WIDTH-1:0]     ARID,
    output logic [ADDR_WIDTH-1:0]   ARADDR,
    output logic [LEN_WIDTH-1:0]    ARLEN,
    output logic [2:0]              ARSIZE,
    output logic [1:0]              ARBURST,
    output logic                    ARVALID,
    input  logic                    ARREADY,
    input  logic [ID_WIDTH-1:0]     RID,
    input  logic [DATA_WIDTH-1:0]   RDATA,
    input  logic [1:0]              RRESP,
    input  logic                    RLAST,
    input  logic                    RVALID,
    output logic                    RREADY,
    output logic [ID_WIDTH-1:0]     AWID,
    output logic [ADDR_WIDTH-1:0]   AWADDR,
    output logic [LEN_WIDTH-1:0]    AWLEN,
    output logic [2:0]              AWSIZE,
    output logic [1:0]              AWBURST,
    output logic                    AWVALID,
    input  logic                    AWREADY,
    output logic [DATA_WIDTH-1:0]   WDATA,
    output logic [DATA_WIDTH/8-1:0] WSTRB,
    output logic                    WLAST,
    output logic                    WVALID,
    input  logic                    WREADY,
    input  logic [ID_WIDTH-1:0]     BID,
    input  logic [1:0]              BRESP,
    input  logic                    BVALID,
    output logic                    BREADY
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_REQ  = 3'd3,
        WR_RESP = 3'd4
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH/8-1:0] wstrb_q;
    logic                    aw_done;
    logic                    w_done;

    // Word-aligned transfers only: low address bits and the OKAY/EXOKAY distinction are don't-care.
    logic unused_bits;
    assign unused_bits = ^{req_addr[1:0], RRESP[0], BRESP[0]};

    // Single-beat, full-word INCR bursts with a fixed master ID.
    assign ARID    = MASTER_ID;
    assign ARADDR  = addr_q;
    assign ARLEN   = '0;
    assign ARSIZE  = 3'b010;
    assign ARBURST = 2'b01;
    assign AWID    = MASTER_ID;
    assign AWADDR  = addr_q;
    assign AWLEN   = '0;
    assign AWSIZE  = 3'b010;
    assign AWBURST = 2'b01;
    assign WDATA   = wdata_q;
    assign WSTRB   = wstrb_q;
    assign WLAST   = 1'b1;

    // State register.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state and channel handshake outputs, all decoded from the current state.
    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        ARVALID   = 1'b0;
        RREADY    = 1'b0;
        AWVALID   = 1'b0;
        WVALID    = 1'b0;
        BREADY    = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = req_we ? WR_REQ : RD_ADDR;
            end
            RD_ADDR: begin
                ARVALID = 1'b1;
                if (ARREADY) state_nxt = RD_DATA;
            end
            RD_DATA: begin
                RREADY = 1'b1;
                if (RVALID) state_nxt = IDLE;
            end
            WR_REQ: begin
                AWVALID = !aw_done;
                WVALID  = !w_done;
                // AW and W complete independently; leave once both have been accepted.
                if ((aw_done || AWREADY) && (w_done || WREADY)) state_nxt = WR_RESP;
            end
            WR_RESP: begin
                BREADY = 1'b1;
                if (BVALID) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request capture, write-channel completion flags and the registered response.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
        end else begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            if (state == IDLE && req_valid) begin
                addr_q  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
                wdata_q <= req_wdata;
                wstrb_q <= req_wstrb;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
            if (state == WR_REQ) begin
                if (AWVALID && AWREADY) aw_done <= 1'b1;
                if (WVALID && WREADY)   w_done  <= 1'b1;
            end
            if (state == RD_DATA && RVALID) begin
                resp_valid <= 1'b1;
                resp_rdata <= RDATA;
                resp_err   <= RRESP[1] | (RID != MASTER_ID) | ~RLAST;
            end
            if (state == WR_RESP && BVALID) begin
                resp_valid <= 1'b1;
                resp_err   <= BRESP[1] | (BID != MASTER_ID);
            end
        end
    end

endmodule

// File: tb/tb_axi_master_bridge.sv
// Bench for axi_master_bridge: a cycle-stepped AXI slave with programmable ready/valid delays
// drives the bridge; expected latency, addresses, data and error flags come from the
// transaction description alone.
module tb_axi_master_bridge;

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic [3:0]  ARID, AWID, RID, BID, ARLEN, AWLEN;
    logic [31:0] ARADDR, AWADDR, RDATA, WDATA;
    logic [2:0]  ARSIZE, AWSIZE;
    logic [1:0]  ARBURST, AWBURST, RRESP, BRESP;
    logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;
    logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
    logic [3:0]  WSTRB;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] last_rdata = 32'h0;

    always #5 ACLK = ~ACLK;

    axi_master_bridge dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
    );

    task automatic slave_idle();
        ARREADY = 0; AWREADY = 0; WREADY = 0; RVALID = 0; BVALID = 0;
        RID = 0; RDATA = 0; RRESP = 0; RLAST = 0; BID = 0; BRESP = 0;
    endtask

    // One complete transaction. Called at a negedge; returns at the negedge where resp_valid is seen.
    task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input int ar_dly, input int aw_dly,
                          input int w_dly, input int r_dly, input int b_dly,
                          input logic [31:0] rdata, input logic [1:0] rresp, input logic [3:0] rid,
                          input logic rlast, input logic [1:0] bresp, input logic [3:0] bid,
                          input string name);
        int exp_lat, lat, cyc;
        int ar_cnt, aw_cnt, w_cnt, r_cnt, b_cnt;
        int ar_hs, aw_hs, w_hs, r_hs, b_hs;
        int ar_first, aw_first, w_first;
        logic ar_pend, aw_pend, w_pend, proto_ok, got, got_err, exp_err;
        logic [31:0] got_rdata, exp_rdata, exp_addr;
        exp_lat   = we ? 3 + ((aw_dly > w_dly) ? aw_dly : w_dly) + b_dly : 3 + ar_dly + r_dly;
        exp_err   = we ? (bresp[1] || bid != 4'h0) : (rresp[1] || rid != 4'h0 || !rlast);
        exp_rdata = we ? last_rdata : rdata;
        exp_addr  = {addr[31:2], 2'b00};
        ar_cnt = 0; aw_cnt = 0; w_cnt = 0; r_cnt = 0; b_cnt = 0;
        ar_hs = 0; aw_hs = 0; w_hs = 0; r_hs = 0; b_hs = 0;
        ar_first = -1; aw_first = -1; w_first = -1;
        ar_pend = 0; aw_pend = 0; w_pend = 0; proto_ok = 1; got = 0;
        got_err = 0; got_rdata = 0; lat = -1;

        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s accept_ready got=%b exp=1", name, req_ready);
        end
        req_valid = 1; req_we = we; req_addr = addr; req_wdata = wdata; req_wstrb = wstrb;
        @(posedge ACLK);
        for (cyc = 1; cyc <= 200; cyc++) begin
            @(negedge ACLK);
            req_valid = 0; req_addr = $urandom; req_wdata = $urandom; req_wstrb = 4'($urandom);
            if (resp_valid === 1'b1) begin
                got = 1; lat = cyc; got_err = resp_err; got_rdata = resp_rdata;
                slave_idle();
                break;
            end
            // R and B see only handshakes from earlier cycles.
            if (!we && ar_hs > 0 && r_hs == 0) begin
                RVALID = (r_cnt >= r_dly); r_cnt++;
                RDATA = rdata; RRESP = rresp; RID = rid; RLAST = rlast;
                if (RVALID && RREADY) r_hs++;
            end else begin
                RVALID = we ? 1'($urandom) : 1'b0;
                RDATA = $urandom; RID = 4'($urandom); RRESP = 2'($urandom); RLAST = 1'($urandom);
            end
            if (we && aw_hs > 0 && w_hs > 0 && b_hs == 0) begin
                BVALID = (b_cnt >= b_dly); b_cnt++;
                BRESP = bresp; BID = bid;
                if (BVALID && BREADY) b_hs++;
            end else begin
                BVALID = we ? 1'b0 : 1'($urandom);
                BID = 4'($urandom); BRESP = 2'($urandom);
            end
            if (ar_pend && !ARVALID) proto_ok = 0;
            if (aw_pend && !AWVALID) proto_ok = 0;
            if (w_pend && !WVALID) proto_ok = 0;
            if (we && ARVALID) proto_ok = 0;
            if (!we && (AWVALID || WVALID)) proto_ok = 0;
            ARREADY = 0; AWREADY = 0; WREADY = 0;
            if (ARVALID) begin
                if (ar_first < 0) ar_first = cyc;
                if (ARADDR !== exp_addr || ARLEN !== 4'h0 || ARSIZE !== 3'b010 ||
                    ARBURST !== 2'b01 || ARID !== 4'h0) proto_ok = 0;
                ARREADY = (ar_cnt >= ar_dly); ar_cnt++;
                if (ARREADY) ar_hs++;
            end
            if (AWVALID) begin
                if (aw_first < 0) aw_first = cyc;
                if (AWADDR !== exp_addr || AWLEN !== 4'h0 || AWSIZE !== 3'b010 ||
                    AWBURST !== 2'b01 || AWID !== 4'h0) proto_ok = 0;
                AWREADY = (aw_cnt >= aw_dly); aw_cnt++;
                if (AWREADY) aw_hs++;
            end
            if (WVALID) begin
                if (w_first < 0) w_first = cyc;
                if (WDATA !== wdata || WSTRB !== wstrb || WLAST !== 1'b1) proto_ok = 0;
                WREADY = (w_cnt >= w_dly); w_cnt++;
                if (WREADY) w_hs++;
            end
            ar_pend = ARVALID && !ARREADY;
            aw_pend = AWVALID && !AWREADY;
            w_pend  = WVALID && !WREADY;
        end

        checks++;
        if (!got) begin
            failures++;
            $display("FAIL %s resp_timeout got=none exp=resp_valid by cycle %0d", name, exp_lat);
        end
        checks++;
        if (lat != exp_lat) begin
            failures++;
            $display("FAIL %s latency got=%0d exp=%0d", name, lat, exp_lat);
        end
        checks++;
        if (got_err !== exp_err) begin
            failures++;
            $display("FAIL %s resp_err got=%b exp=%b", name, got_err, exp_err);
        end
        checks++;
        if (got_rdata !== exp_rdata) begin
            failures++;
            $display("FAIL %s resp_rdata got=%h exp=%h", name, got_rdata, exp_rdata);
        end
        checks++;
        if (we ? (aw_hs != 1 || w_hs != 1 || b_hs != 1 || aw_cnt != aw_dly + 1 || w_cnt != w_dly + 1)
               : (ar_hs != 1 || r_hs != 1 || ar_cnt != ar_dly + 1)) begin
            failures++;
            $display("FAIL %s beats got=ar%0d/aw%0d/w%0d/r%0d/b%0d awcyc=%0d wcyc=%0d arcyc=%0d exp=one beat per channel, valid for dly+1 cycles",
                     name, ar_hs, aw_hs, w_hs, r_hs, b_hs, aw_cnt, w_cnt, ar_cnt);
        end
        checks++;
        if (we ? (aw_first != 1 || w_first != 1) : (ar_first != 1)) begin
            failures++;
            $display("FAIL %s first_valid got=ar%0d/aw%0d/w%0d exp=cycle 1", name, ar_first, aw_first, w_first);
        end
        checks++;
        if (!proto_ok) begin
            failures++;
            $display("FAIL %s axi_protocol got=violation exp=stable fields and no early valid drop", name);
        end
        if (got && !we) last_rdata = rdata;
    endtask

    task automatic check_idle_outputs(input string name);
        checks++;
        if ({req_ready, ARVALID, AWVALID, WVALID, RREADY, BREADY, resp_valid} !== 7'b1000000) begin
            failures++;
            $display("FAIL %s idle_outputs got=%b exp=1000000", name,
                     {req_ready, ARVALID, AWVALID, WVALID, RREADY, BREADY, resp_valid});
        end
    endtask

    task automatic test_reset();
        ARESETn = 0; req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; req_wstrb = 0;
        slave_idle();
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        check_idle_outputs("reset");
        checks++;
        if (resp_rdata !== 32'h0 || resp_err !== 1'b0) begin
            failures++;
            $display("FAIL reset resp_fields got=%h/%b exp=00000000/0", resp_rdata, resp_err);
        end
        ARESETn = 1;
        @(negedge ACLK);
        last_rdata = 32'h0;
    endtask

    task automatic test_load_basic();
        do_txn(0, 32'h0000_0010, 0, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 2'b00, 4'h0, 1, 2'b00, 4'h0, "load_basic");
        @(negedge ACLK);
    endtask

    task automatic test_store_aw_delay();
        do_txn(1, 32'h0000_0022, 32'hCAFEF00D, 4'b0011, 0, 3, 0, 0, 0, 0, 0, 0, 1, 2'b00, 4'h0, "store_aw_delay");
        @(negedge ACLK);
    endtask

    task automatic test_store_w_late_and_same();
        do_txn(1, 32'h0000_1004, 32'h1234_5678, 4'b1111, 0, 1, 3, 0, 1, 0, 0, 0, 1, 2'b00, 4'h0, "store_w_late");
        @(negedge ACLK);
        do_txn(1, 32'h0000_2008, 32'h8765_4321, 4'b0000, 0, 2, 2, 0, 0, 0, 0, 0, 1, 2'b01, 4'h0, "store_same_cycle");
        @(negedge ACLK);
    endtask

    task automatic test_error_responses();
        do_txn(0, 32'h0000_0040, 0, 0, 1, 0, 0, 2, 0, 32'h0BAD_0BAD, 2'b10, 4'h0, 1, 0, 0, "load_slverr");
        @(negedge ACLK);
        do_txn(1, 32'h0000_0044, 32'h5555_AAAA, 4'b1000, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 4'h5, "store_bad_bid");
        @(negedge ACLK);
        do_txn(0, 32'h0000_0048, 0, 0, 0, 0, 0, 0, 0, 32'h1111_2222, 2'b00, 4'h0, 0, 0, 0, "load_no_rlast");
        @(negedge ACLK);
    endtask

    task automatic test_reset_mid_read();
        req_valid = 1; req_we = 0; req_addr = 32'h0000_0080;
        @(posedge ACLK);
        @(negedge ACLK);
        req_valid = 0; ARREADY = 1;
        @(posedge ACLK);
        @(negedge ACLK);
        ARREADY = 0;
        checks++;
        if (RREADY !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid rready_before_reset got=%b exp=1", RREADY);
        end
        ARESETn = 0;
        @(posedge ACLK);
        @(negedge ACLK);
        check_idle_outputs("reset_mid_read");
        ARESETn = 1;
        last_rdata = 32'h0;
        for (int i = 0; i < 3; i++) begin
            RVALID = 1; RDATA = $urandom; RRESP = 0; RID = 0; RLAST = 1;
            @(negedge ACLK);
            checks++;
            if (resp_valid !== 1'b0 || RREADY !== 1'b0 || resp_rdata !== 32'h0) begin
                failures++;
                $display("FAIL reset_mid stray_rvalid got=rv%b rr%b rd%h exp=rv0 rr0 rd00000000",
                         resp_valid, RREADY, resp_rdata);
            end
        end
        slave_idle();
        @(negedge ACLK);
    endtask

    task automatic test_back_to_back();
        do_txn(1, 32'h0000_0100, 32'hA5A5_5A5A, 4'b0101, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 4'h0, "b2b_store");
        do_txn(0, 32'h0000_0104, 0, 0, 0, 0, 0, 0, 0, 32'h0F0F_F0F0, 2'b00, 4'h0, 1, 0, 0, "b2b_load");
        do_txn(1, 32'h0000_0108, 32'h0000_0001, 4'b0001, 0, 1, 0, 0, 0, 0, 0, 0, 1, 2'b00, 4'h0, "b2b_store2");
        @(negedge ACLK);
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            logic we;
            we = 1'($urandom);
            do_txn(we, $urandom, $urandom, 4'($urandom),
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom, 2'($urandom), ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0,
                   ($urandom_range(0, 4) != 0), 2'($urandom),
                   ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0, "random");
            if ($urandom_range(0, 1) == 1) begin
                @(negedge ACLK);
                checks++;
                if (resp_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL random resp_pulse_width got=%b exp=0", resp_valid);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_basic();
        test_store_aw_delay();
        test_store_w_late_and_same();
        test_error_responses();
        test_reset_mid_read();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi_master_bridge.md
Name: axi_master_bridge

Overview:
- Converts single-word load/store requests from the CPU core memory port into single-beat AXI4 transactions.
- Sits directly upstream of SRAM_wrapper and drives its full AR/R/AW/W/B channel set.
- One outstanding transaction at a time. The core stalls on req_ready until the response pulse arrives.

Parameters:
- ADDR_WIDTH, 32, byte address width of req_addr and ARADDR/AWADDR
- DATA_WIDTH, 32, data width; STRB = DATA_WIDTH/8
- ID_WIDTH, 4, width of ARID/AWID/RID/BID
- LEN_WIDTH, 4, width of ARLEN/AWLEN
- MASTER_ID, 4'h0, constant ID driven on ARID/AWID and expected on RID/BID

Ports:
- ACLK  in  1  clock, all logic on rising edge
- ARESETn  in  1  synchronous active-low reset
- req_valid  in  1  core request valid
- req_ready  out  1  bridge can accept a request
- req_we  in  1  1=store, 0=load
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  DATA_WIDTH  store data
- req_wstrb  in  DATA_WIDTH/8  store byte enables
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  DATA_WIDTH  load data, valid with resp_valid
- resp_err  out  1  error flag, valid with resp_valid
- ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARVALID  out  ID_WIDTH/ADDR_WIDTH/LEN_WIDTH/3/2/1  read address channel
- ARREADY  in  1
- RID/RDATA/RRESP/RLAST/RVALID  in  ID_WIDTH/DATA_WIDTH/2/1/1  read data channel
- RREADY  out  1
- AWID/AWADDR/AWLEN/AWSIZE/AWBURST/AWVALID  out  ID_WIDTH/ADDR_WIDTH/LEN_WIDTH/3/2/1  write address channel
- AWREADY  in  1
- WDATA/WSTRB/WLAST/WVALID  out  DATA_WIDTH/DATA_WIDTH/8/1/1  write data channel
- WREADY  in  1
- BID/BRESP/BVALID  in  ID_WIDTH/2/1  write response channel
- BREADY  out  1

Behaviour:
- Clock and reset: one clock, ACLK. Reset ARESETn is synchronous and active-low.
- Reset values: state=IDLE; ARVALID, AWVALID, WVALID, RREADY, BREADY, resp_valid, resp_err = 0; resp_rdata = 0; req_ready = 1.
- Reset mid-transaction: everything returns to reset values on the next edge. No pending handshake is completed.
- Constant fields:
  - ARLEN/AWLEN = 0
  - ARSIZE/AWSIZE = 3'b010
  - ARBURST/AWBURST = 2'b01 (INCR)
  - ARID/AWID = MASTER_ID
  - WLAST = 1 whenever WVALID = 1
- Address: ARADDR/AWADDR = latched req_addr with bits [1:0] forced to 0.
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid, latch addr/wdata/wstrb/we.
  - Go to WR_REQ if we=1, else RD_ADDR.
  - req_ready is combinationally 1 only in IDLE.
- RD_ADDR:
  - ARVALID = 1; address held stable until ARREADY.
  - On ARVALID&&ARREADY, go to RD_DATA.
- RD_DATA:
  - RREADY = 1.
  - On RVALID, register RDATA into resp_rdata and pulse resp_valid the next cycle.
  - resp_err = RRESP[1] | (RID != MASTER_ID) | ~RLAST.
  - Return to IDLE.
- WR_REQ:
  - AWVALID and WVALID both assert on entry.
  - Each drops independently after its own handshake; completion is tracked with aw_done/w_done flags.
  - Either channel may complete first, or both in the same cycle.
  - When both are done, go to WR_RESP.
  - WDATA/WSTRB are held stable until WREADY.
- WR_RESP:
  - BREADY = 1.
  - On BVALID, pulse resp_valid the next cycle with resp_err = BRESP[1] | (BID != MASTER_ID).
  - resp_rdata is unchanged on writes.
  - Return to IDLE.
- Ordering: resp_valid is asserted in the same cycle the FSM is back in IDLE. A new request may therefore be accepted in the same cycle as the resp_valid pulse.
- Latency, zero wait states:
  - Read: accept at cycle 0 → ARVALID cycle 1 → RVALID/RREADY cycle 2 → resp_valid cycle 3.
  - Write: accept at cycle 0 → AW+W handshakes cycle 1 → BVALID/BREADY cycle 2 → resp_valid cycle 3.
- AXI rule: no valid is ever deasserted before its ready has been seen.
- Inputs outside the active state are ignored:
  - RVALID while not in RD_DATA.
  - BVALID while not in WR_RESP.
- req_wstrb = 0 is passed through unchanged; the transaction is still issued.

Test Plan:
- Reset, then load at req_addr=0x0000_0010 with slave returning RDATA=0xDEADBEEF, RRESP=0 at zero wait → ARADDR=0x10, ARVALID cycle 1; resp_valid cycle 3; resp_rdata=0xDEADBEEF; resp_err=0.
- Store 0xCAFEF00D, wstrb=4'b0011 to 0x0000_0022; slave delays AWREADY 3 cycles, WREADY immediate → AWADDR=0x20; WVALID drops after cycle 1; AWVALID held 4 cycles; single B handshake; resp_valid with resp_err=0.
- Store with WREADY delayed 2 cycles after AWREADY, and a second store with both ready in the same cycle → exactly one AW and one W beat each; WLAST=1 on each.
- Load returning RRESP=2'b10, then a store returning BID=4'h5 → resp_err=1 for both.
- Reset asserted while in RD_DATA (RVALID not yet seen) → next cycle all valids=0, req_ready=1; a later RVALID is ignored with resp_valid=0.
- Back-to-back: load issued in the same cycle resp_valid of the preceding store is pulsed → ARVALID the following cycle; no idle bubble beyond the one-cycle accept.
